// File: rtl/cdb_pkg.sv
// Common data bus shared definitions: default widths and the broadcast message type.
// Used by the CDB broadcaster, the reservation stations and the register file.
package cdb_pkg;

  localparam int CDB_NUM_SRC    = 4;
  localparam int CDB_TAG_WIDTH  = 7;
  localparam int CDB_DATA_WIDTH = 32;
  localparam int CDB_FIFO_DEPTH = 2;

  // One completed result as carried on the bus.
  typedef struct packed {
    logic [CDB_TAG_WIDTH-1:0]  tag;
    logic [CDB_DATA_WIDTH-1:0] data;
  } cdb_msg_t;

endpackage

// File: rtl/cdb_broadcaster_if.sv
// Result-offer and broadcast signals of the CDB broadcaster.
// master: the side producing results and consuming the broadcast (units / testbench).
// slave:  the broadcaster itself.
interface cdb_broadcaster_if #(
  parameter int NUM_SRC    = cdb_pkg::CDB_NUM_SRC,
  parameter int TAG_WIDTH  = cdb_pkg::CDB_TAG_WIDTH,
  parameter int DATA_WIDTH = cdb_pkg::CDB_DATA_WIDTH
) ();

  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_ready;
  logic [NUM_SRC*TAG_WIDTH-1:0]  src_tag;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;

  logic                          cdb_valid;
  logic [TAG_WIDTH-1:0]          cdb_tag;
  logic [DATA_WIDTH-1:0]         cdb_data;
  logic [SRC_W-1:0]              cdb_src;

  modport master (
    output src_valid, src_tag, src_data,
    input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  src_valid, src_tag, src_data,
    output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer for the CDB broadcaster. Power-of-two depth, pointers wrap
// naturally; flush empties it without touching the storage array.
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter int  DEPTH = CDB_FIFO_DEPTH,
  parameter type msg_t = cdb_msg_t
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  msg_t din,
  output msg_t dout,
  output logic empty,
  output logic full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  msg_t             mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  // Never overfill or underflow, even if a caller misbehaves.
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  assign empty = (count_r == {CNT_W{1'b0}});
  assign full  = (count_r == CNT_MAX);
  assign dout  = mem_r[rd_ptr_r];

  // Storage write; data needs no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (push_s && !flush && !reset) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; reset beats flush, flush beats push/pop.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Transmit side of the common data bus. Buffers completed results per functional unit,
// picks one non-empty buffer per cycle round-robin and drives it as a registered broadcast.
module cdb_broadcaster
  import cdb_pkg::*;
#(
  parameter int NUM_SRC    = CDB_NUM_SRC,
  parameter int TAG_WIDTH  = CDB_TAG_WIDTH,
  parameter int DATA_WIDTH = CDB_DATA_WIDTH,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  cdb_broadcaster_if.slave   bus
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam logic [SRC_W-1:0] SRC_ONE = SRC_W'(1);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } msg_t;

  logic [NUM_SRC-1:0]   empty_s;
  logic [NUM_SRC-1:0]   full_s;
  logic [NUM_SRC-1:0]   ready_s;
  logic [NUM_SRC-1:0]   push_s;
  logic [NUM_SRC-1:0]   pop_s;
  logic [NUM_SRC-1:0]   req_s;
  logic [2*NUM_SRC-1:0] req2_s;
  logic [NUM_SRC-1:0]   rot_s;
  logic [SRC_W-1:0]     enc_s;
  logic [SRC_W-1:0]     winner_s;
  logic                 grant_s;
  msg_t                 din_s  [NUM_SRC];
  msg_t                 head_s [NUM_SRC];
  msg_t                 win_msg_s;

  logic                  cdb_valid_r;
  logic [TAG_WIDTH-1:0]  cdb_tag_r;
  logic [DATA_WIDTH-1:0] cdb_data_r;
  logic [SRC_W-1:0]      cdb_src_r;
  logic [SRC_W-1:0]      rr_ptr_r;

  // Ready depends only on buffer occupancy: a same-cycle pop does not free a slot early.
  assign ready_s = ~full_s & {NUM_SRC{!reset && !flush}};
  assign push_s  = bus.src_valid & ready_s;
  assign req_s   = ~empty_s;
  assign grant_s = |req_s;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign din_s[gi].tag  = bus.src_tag[gi*TAG_WIDTH +: TAG_WIDTH];
    assign din_s[gi].data = bus.src_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign pop_s[gi]      = grant_s && !flush && (winner_s == SRC_W'(gi));

    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .msg_t (msg_t)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_s[gi]),
      .pop   (pop_s[gi]),
      .flush (flush),
      .din   (din_s[gi]),
      .dout  (head_s[gi]),
      .empty (empty_s[gi]),
      .full  (full_s[gi])
    );
  end

  // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the lowest set bit,
  // then rotate the index back.
  always_comb begin
    req2_s = {req_s, req_s};
    rot_s  = req2_s[rr_ptr_r +: NUM_SRC];
    enc_s  = {SRC_W{1'b0}};
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      if (rot_s[j]) begin
        enc_s = SRC_W'(j);
      end else begin
        enc_s = enc_s;
      end
    end
    winner_s  = rr_ptr_r + enc_s;
    win_msg_s = head_s[winner_s];
  end

  // Broadcast register and round-robin pointer; idle cycles keep the last tag/data/src.
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= {TAG_WIDTH{1'b0}};
      cdb_data_r  <= {DATA_WIDTH{1'b0}};
      cdb_src_r   <= {SRC_W{1'b0}};
      rr_ptr_r    <= {SRC_W{1'b0}};
    end else if (flush) begin
      cdb_valid_r <= 1'b0;
    end else if (grant_s) begin
      cdb_valid_r <= 1'b1;
      cdb_tag_r   <= win_msg_s.tag;
      cdb_data_r  <= win_msg_s.data;
      cdb_src_r   <= winner_s;
      rr_ptr_r    <= winner_s + SRC_ONE;
    end else begin
      cdb_valid_r <= 1'b0;
    end
  end

  assign bus.src_ready = ready_s;
  assign bus.cdb_valid = cdb_valid_r;
  assign bus.cdb_tag   = cdb_tag_r;
  assign bus.cdb_data  = cdb_data_r;
  assign bus.cdb_src   = cdb_src_r;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: vector table, directed corner sequences and
// randomized traffic, all compared against a queue-based model of the bus rules.
module tb_cdb_broadcaster;

  localparam int NS = 4;
  localparam int TW = 7;
  localparam int DW = 32;
  localparam int FD = 2;

  logic clock;
  logic reset;
  logic flush;

  cdb_broadcaster_if #(.NUM_SRC(NS), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) bus ();

  cdb_broadcaster #(
    .NUM_SRC    (NS),
    .TAG_WIDTH  (TW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue of pending results per source plus the visible bus state.
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq [NS][$];
  int            m_rr    = 0;
  logic          m_valid = 1'b0;
  logic [TW-1:0] m_tag   = '0;
  logic [DW-1:0] m_data  = '0;
  logic [1:0]    m_src   = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check ready, advance the model, check the bus after the edge.
  task automatic cycle(input logic rst, input logic fl, input logic [NS-1:0] v,
                       input logic [NS*TW-1:0] tags, input logic [NS*DW-1:0] datas,
                       output logic [NS-1:0] acc, output logic [NS-1:0] rdy_seen);
    logic [NS-1:0] exp_rdy;
    int   win;
    int   s;
    ent_t e;
    reset         = rst;
    flush         = fl;
    bus.src_valid = v;
    bus.src_tag   = tags;
    bus.src_data  = datas;
    for (int i = 0; i < NS; i++) exp_rdy[i] = (mq[i].size() < FD) && !rst && !fl;
    #1;
    rdy_seen = bus.src_ready;
    chk("src_ready", {60'd0, bus.src_ready}, {60'd0, exp_rdy});
    acc = v & exp_rdy;
    if (rst) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      m_rr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = '0;
    end else if (fl) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      m_valid = 1'b0;
    end else begin
      win = -1;
      for (int k = 0; k < NS; k++) begin
        s = (m_rr + k) % NS;
        if (win < 0 && mq[s].size() > 0) win = s;
      end
      for (int i = 0; i < NS; i++) begin
        if (acc[i]) begin
          e.tag  = tags[i*TW +: TW];
          e.data = datas[i*DW +: DW];
          mq[i].push_back(e);
        end
      end
      if (win >= 0) begin
        e       = mq[win].pop_front();
        m_valid = 1'b1;
        m_tag   = e.tag;
        m_data  = e.data;
        m_src   = 2'(win);
        m_rr    = (win + 1) % NS;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    chk("cdb_valid", {63'd0, bus.cdb_valid}, {63'd0, m_valid});
    chk("cdb_tag",   {57'd0, bus.cdb_tag},   {57'd0, m_tag});
    chk("cdb_data",  {32'd0, bus.cdb_data},  {32'd0, m_data});
    chk("cdb_src",   {62'd0, bus.cdb_src},   {62'd0, m_src});
  endtask

  typedef struct {
    logic          rst;
    logic          fl;
    logic [NS-1:0] v;
    logic [TW-1:0] tbase;
    logic [NS-1:0] e_rdy;
    logic          e_val;
    logic [1:0]    e_src;
    logic [TW-1:0] e_tag;
  } vec_t;

  vec_t vecs [21];

  logic [NS*TW-1:0] tags;
  logic [NS*DW-1:0] datas;
  logic [NS-1:0]    acc;
  logic [NS-1:0]    rdy;
  logic [TW-1:0]    tcnt [NS];
  logic             dropped;

  initial begin
    reset = 1'b1; flush = 1'b0;
    bus.src_valid = '0; bus.src_tag = '0; bus.src_data = '0;

    //            rst   fl    v     tbase  e_rdy e_val e_src e_tag
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 7'h00, 4'h0, 1'b0, 2'd0, 7'h00};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 7'h00, 4'h0, 1'b0, 2'd0, 7'h00};
    vecs[2]  = '{1'b1, 1'b0, 4'h0, 7'h00, 4'h0, 1'b0, 2'd0, 7'h00};
    vecs[3]  = '{1'b0, 1'b0, 4'h0, 7'h00, 4'hF, 1'b0, 2'd0, 7'h00};
    vecs[4]  = '{1'b0, 1'b0, 4'hF, 7'h20, 4'hF, 1'b0, 2'd0, 7'h00};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 7'h00, 4'hF, 1'b1, 2'd0, 7'h20};
    vecs[6]  = '{1'b0, 1'b0, 4'h0, 7'h00, 4'hF, 1'b1, 2'd1, 7'h21};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 7'h00, 4'hF, 1'b1, 2'd2, 7'h22};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 7'h00, 4'hF, 1'b1, 2'd3, 7'h23};
    vecs[9]  = '{1'b0, 1'b0, 4'h0, 7'h00, 4'hF, 1'b0, 2'd3, 7'h23};
    vecs[10] = '{1'b0, 1'b0, 4'h9, 7'h30, 4'hF, 1'b0, 2'd3, 7'h23};
    vecs[11] = '{1'b0, 1'b0, 4'h1, 7'h40, 4'hF, 1'b1, 2'd0, 7'h30};
    vecs[12] = '{1'b0, 1'b1, 4'hF, 7'h50, 4'h0, 1'b0, 2'd0, 7'h30};
    vecs[13] = '{1'b0, 1'b0, 4'h0, 7'h00, 4'hF, 1'b0, 2'd0, 7'h30};
    vecs[14] = '{1'b0, 1'b0, 4'h0, 7'h00, 4'hF, 1'b0, 2'd0, 7'h30};
    vecs[15] = '{1'b0, 1'b0, 4'hF, 7'h60, 4'hF, 1'b0, 2'd0, 7'h30};
    vecs[16] = '{1'b0, 1'b0, 4'h0, 7'h00, 4'hF, 1'b1, 2'd1, 7'h61};
    vecs[17] = '{1'b0, 1'b0, 4'h0, 7'h00, 4'hF, 1'b1, 2'd2, 7'h62};
    vecs[18] = '{1'b0, 1'b0, 4'h0, 7'h00, 4'hF, 1'b1, 2'd3, 7'h63};
    vecs[19] = '{1'b0, 1'b0, 4'h0, 7'h00, 4'hF, 1'b1, 2'd0, 7'h60};
    vecs[20] = '{1'b0, 1'b0, 4'h0, 7'h00, 4'hF, 1'b0, 2'd0, 7'h60};

    // Reset hold, all-source burst in rr order, flush with rr_ptr kept.
    for (int n = 0; n < 21; n++) begin
      for (int i = 0; i < NS; i++) begin
        tags[i*TW +: TW]  = vecs[n].tbase + 7'(i);
        datas[i*DW +: DW] = {8'hC0, 8'(n), 9'h000, vecs[n].tbase + 7'(i)};
      end
      cycle(vecs[n].rst, vecs[n].fl, vecs[n].v, tags, datas, acc, rdy);
      chk($sformatf("tbl%0d_ready", n), {60'd0, rdy},           {60'd0, vecs[n].e_rdy});
      chk($sformatf("tbl%0d_valid", n), {63'd0, bus.cdb_valid}, {63'd0, vecs[n].e_val});
      chk($sformatf("tbl%0d_src", n),   {62'd0, bus.cdb_src},   {62'd0, vecs[n].e_src});
      chk($sformatf("tbl%0d_tag", n),   {57'd0, bus.cdb_tag},   {57'd0, vecs[n].e_tag});
    end

    // Single push on src2: broadcast one cycle later, for exactly one cycle.
    tags = '0; datas = '0;
    tags[2*TW +: TW]  = 7'h15;
    datas[2*DW +: DW] = 32'hDEADBEEF;
    cycle(1'b0, 1'b0, 4'b0100, tags, datas, acc, rdy);
    chk("t2_no_bypass", {63'd0, bus.cdb_valid}, 64'd0);
    cycle(1'b0, 1'b0, 4'b0000, '0, '0, acc, rdy);
    chk("t2_valid", {63'd0, bus.cdb_valid}, 64'd1);
    chk("t2_tag",   {57'd0, bus.cdb_tag},   64'h15);
    chk("t2_data",  {32'd0, bus.cdb_data},  64'hDEADBEEF);
    chk("t2_src",   {62'd0, bus.cdb_src},   64'd2);
    cycle(1'b0, 1'b0, 4'b0000, '0, '0, acc, rdy);
    chk("t2_single", {63'd0, bus.cdb_valid}, 64'd0);

    // Reset with two results buffered on src1 and a broadcast in flight.
    tags = '0; datas = '0;
    tags[0*TW +: TW] = 7'h70; tags[1*TW +: TW] = 7'h71;
    datas[0*DW +: DW] = 32'h7000_0070; datas[1*DW +: DW] = 32'h7100_0071;
    cycle(1'b0, 1'b0, 4'b0011, tags, datas, acc, rdy);
    tags[0*TW +: TW] = 7'h72; tags[1*TW +: TW] = 7'h73;
    cycle(1'b0, 1'b0, 4'b0011, tags, datas, acc, rdy);
    chk("t6_busy_valid", {63'd0, bus.cdb_valid}, 64'd1);
    chk("t6_busy_src",   {62'd0, bus.cdb_src},   64'd0);
    cycle(1'b1, 1'b0, 4'b0000, '0, '0, acc, rdy);
    chk("t6_rst_ready", {60'd0, rdy},           64'd0);
    chk("t6_rst_valid", {63'd0, bus.cdb_valid}, 64'd0);
    chk("t6_rst_tag",   {57'd0, bus.cdb_tag},   64'd0);
    chk("t6_rst_data",  {32'd0, bus.cdb_data},  64'd0);
    chk("t6_rst_src",   {62'd0, bus.cdb_src},   64'd0);
    cycle(1'b0, 1'b0, 4'b0000, '0, '0, acc, rdy);
    chk("t6_lost", {63'd0, bus.cdb_valid}, 64'd0);
    tags = '0; datas = '0;
    tags[1*TW +: TW] = 7'h01; datas[1*DW +: DW] = 32'h0000_1111;
    cycle(1'b0, 1'b0, 4'b0010, tags, datas, acc, rdy);
    cycle(1'b0, 1'b0, 4'b0000, '0, '0, acc, rdy);
    chk("t6_post_valid", {63'd0, bus.cdb_valid}, 64'd1);
    chk("t6_post_tag",   {57'd0, bus.cdb_tag},   64'h01);
    chk("t6_post_src",   {62'd0, bus.cdb_src},   64'd1);

    // Saturation: all sources offer every cycle, incrementing tags per source.
    for (int i = 0; i < NS; i++) tcnt[i] = 7'(i * 32);
    dropped = 1'b0;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NS; i++) begin
        tags[i*TW +: TW]  = tcnt[i];
        datas[i*DW +: DW] = $urandom;
      end
      cycle(1'b0, 1'b0, 4'hF, tags, datas, acc, rdy);
      for (int i = 0; i < NS; i++) if (acc[i]) tcnt[i] = tcnt[i] + 7'd1;
      if (rdy != 4'hF) dropped = 1'b1;
      if (k > 0) chk($sformatf("t4_nobubble%0d", k), {63'd0, bus.cdb_valid}, 64'd1);
    end
    chk("t4_ready_drop", {63'd0, dropped}, 64'd1);
    for (int k = 0; k < 12; k++) cycle(1'b0, 1'b0, 4'h0, '0, '0, acc, rdy);
    chk("t4_drained", {63'd0, bus.cdb_valid}, 64'd0);

    // Random traffic with occasional flush and reset.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NS; i++) begin
        tags[i*TW +: TW]  = 7'($urandom);
        datas[i*DW +: DW] = $urandom;
      end
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
            4'($urandom), tags, datas, acc, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
